// File: rtl/ramdisk_pkg.sv
// Shared types and constants for the block-RAM disk: FSM states, cmd_error
// codes and the word-address width helper.
package ramdisk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    READ_DRAIN,
    WRITE,
    WRITE_DRAIN,
    DONE
  } state_t;

  localparam logic [1:0] RD_OK        = 2'd0;
  localparam logic [1:0] RD_ERR_RANGE = 2'd1;
  localparam logic [1:0] RD_ERR_WP    = 2'd2;
  localparam logic [1:0] RD_ERR_CMD   = 2'd3;

  function automatic int ramdisk_aw(input int blocks, input int block_size);
    return $clog2(blocks * block_size);
  endfunction

endpackage

// File: rtl/ramdisk_mem.sv
// Single-port synchronous RAM: registered read with read enable, so the output
// register holds its word until the next read.
module ramdisk_mem #(
  parameter int DEPTH  = 30720,
  parameter int AW     = 15,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              re,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ramdisk_multiblock.sv
// Multi-block RAM disk behind the QSIC controller FIFOs.
// Optional write-protect input enabled by defining RAMDISK_WRITE_PROTECT_EN.
module ramdisk_multiblock
  import ramdisk_pkg::*;
#(
  parameter int BLOCKS     = 120,
  parameter int BLOCK_SIZE = 256,
  parameter int DATA_W     = 16,
  parameter int COUNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  output logic               device_ready,
  input  logic               read_cmd,
  input  logic               write_cmd,
  input  logic [31:0]        block_address,
  input  logic [COUNT_W-1:0] block_count,
  output logic               fifo_clk,
  input  logic [DATA_W-1:0]  write_data,
  output logic               write_data_enable,
  input  logic               write_fifo_empty,
  output logic [DATA_W-1:0]  read_data,
  output logic               read_data_enable,
  input  logic               read_fifo_full,
`ifdef RAMDISK_WRITE_PROTECT_EN
  input  logic               write_protect,
`endif
  output logic               cmd_done,
  output logic [1:0]         cmd_error,
  output logic [2:0]         dbg_state
);

  localparam int AW    = ramdisk_aw(BLOCKS, BLOCK_SIZE);
  localparam int BW    = $clog2(BLOCK_SIZE);
  localparam int CNT_W = COUNT_W + BW + 1;

  // Handshake: a command is taken on any clock edge where device_ready is high
  // and read_cmd or write_cmd is high; FIFO strobes are single-cycle transfers.
  state_t            state, state_n;
  logic              armed;
  logic [AW-1:0]     addr;
  logic [CNT_W-1:0]  remain;
  logic              hold_valid;
  logic              wr_pending;
  logic [1:0]        err_q, err_n;
  logic              load, issue, push, wde;
  logic [COUNT_W:0]  cnt_n;
  logic [32:0]       end_blk;
  logic              range_err;
  logic [AW-1:0]     start_addr;
  logic [CNT_W-1:0]  total;
  logic [DATA_W-1:0] ram_q;

  assign cnt_n      = (block_count == '0) ? {1'b1, {COUNT_W{1'b0}}} : {1'b0, block_count};
  assign end_blk    = {1'b0, block_address} + 33'(cnt_n);
  assign range_err  = end_blk > 33'(BLOCKS);
  assign start_addr = AW'({{AW{1'b0}}, block_address} * (32 + AW)'(BLOCK_SIZE));
  assign total      = {cnt_n, {BW{1'b0}}};

  assign device_ready      = armed && (state == IDLE);
  assign fifo_clk          = clk;
  assign read_data_enable  = push;
  assign write_data_enable = wde;
  // The RAM output register is the holding register; hold_valid qualifies it.
  assign read_data         = hold_valid ? ram_q : '0;
  assign cmd_done          = (state == DONE);
  assign cmd_error         = (state == DONE) ? err_q : RD_OK;
  assign dbg_state         = state;

  always_comb begin
    state_n = state;
    err_n   = err_q;
    load    = 1'b0;
    push    = hold_valid && !read_fifo_full;
    issue   = (state == READ) && (remain != '0) && (!hold_valid || push);
    wde     = (state == WRITE) && !write_fifo_empty && (remain != '0);
    case (state)
      IDLE: begin
        if (device_ready) begin
          if (read_cmd && write_cmd) begin
            state_n = DONE;
            err_n   = RD_ERR_CMD;
          end else if (read_cmd || write_cmd) begin
            if (range_err) begin
              state_n = DONE;
              err_n   = RD_ERR_RANGE;
            end
`ifdef RAMDISK_WRITE_PROTECT_EN
            else if (write_cmd && write_protect) begin
              state_n = DONE;
              err_n   = RD_ERR_WP;
            end
`endif
            else begin
              load    = 1'b1;
              err_n   = RD_OK;
              state_n = read_cmd ? READ : WRITE;
            end
          end
        end
      end
      READ:        if (issue && remain == CNT_W'(1)) state_n = READ_DRAIN;
      READ_DRAIN:  if (!hold_valid || push) state_n = DONE;
      WRITE:       if (wde && remain == CNT_W'(1)) state_n = WRITE_DRAIN;
      WRITE_DRAIN: state_n = DONE;
      DONE:        state_n = IDLE;
      default:     state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      armed      <= 1'b0;
      addr       <= '0;
      remain     <= '0;
      hold_valid <= 1'b0;
      wr_pending <= 1'b0;
      err_q      <= RD_OK;
    end else begin
      state      <= state_n;
      armed      <= 1'b1;
      err_q      <= err_n;
      wr_pending <= wde;
      if (load) begin
        addr   <= start_addr;
        remain <= total;
      end else begin
        if (issue || wde) remain <= remain - CNT_W'(1);
        if (issue || wr_pending) addr <= addr + AW'(1);
      end
      if (issue) hold_valid <= 1'b1;
      else if (push) hold_valid <= 1'b0;
    end
  end

  ramdisk_mem #(
    .DEPTH (BLOCKS * BLOCK_SIZE),
    .AW    (AW),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk  (clk),
    .re   (issue),
    .we   (wr_pending),
    .addr (addr),
    .wdata(write_data),
    .rdata(ram_q)
  );

endmodule

// File: tb/tb_ramdisk_multiblock.sv
// Self-checking bench for ramdisk_multiblock: FIFO models, a word-array
// reference disk and directed command steps with randomized data and stalls.
module tb_ramdisk_multiblock;
  import ramdisk_pkg::*;

  localparam int BS    = 256;
  localparam int DEPTH = 120 * BS;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        device_ready;
  logic        read_cmd = 1'b0;
  logic        write_cmd = 1'b0;
  logic [31:0] block_address = '0;
  logic [7:0]  block_count = '0;
  logic        fifo_clk;
  logic [15:0] write_data = '0;
  logic        write_data_enable;
  logic        write_fifo_empty = 1'b1;
  logic [15:0] read_data;
  logic        read_data_enable;
  logic        read_fifo_full = 1'b0;
  logic        cmd_done;
  logic [1:0]  cmd_error;
  logic [2:0]  dbg_state;
`ifdef RAMDISK_WRITE_PROTECT_EN
  logic        write_protect = 1'b0;
`endif

  ramdisk_multiblock dut (
    .clk              (clk),
    .reset            (reset),
    .device_ready     (device_ready),
    .read_cmd         (read_cmd),
    .write_cmd        (write_cmd),
    .block_address    (block_address),
    .block_count      (block_count),
    .fifo_clk         (fifo_clk),
    .write_data       (write_data),
    .write_data_enable(write_data_enable),
    .write_fifo_empty (write_fifo_empty),
    .read_data        (read_data),
    .read_data_enable (read_data_enable),
    .read_fifo_full   (read_fifo_full),
`ifdef RAMDISK_WRITE_PROTECT_EN
    .write_protect    (write_protect),
`endif
    .cmd_done         (cmd_done),
    .cmd_error        (cmd_error),
    .dbg_state        (dbg_state)
  );

  // clock / reset block
  always #25 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference disk and scoreboard state
  logic [15:0] ref_mem [DEPTH];
  logic [15:0] src_q[$];
  int          src_idx = 0;
  int          rd_cyc_q[$];
  logic [15:0] rd_data_q[$];
  int          wr_cyc_q[$];
  int          done_cyc_q[$];
  logic [1:0]  done_err_q[$];
  int          rd_viol = 0;
  int          wr_viol = 0;
  bit          stall_en = 1'b0;
  bit          wr_pend = 1'b0;
  logic [15:0] pend_word = '0;
  int          errors = 0;
  int          checks = 0;

  // FIFO models: drive at the falling edge, observe strobes 1 time unit later
  always @(negedge clk) begin
    write_data = wr_pend ? pend_word : 16'($urandom);
    wr_pend = 1'b0;
    read_fifo_full = stall_en && ($urandom_range(0, 1) == 1);
    write_fifo_empty = (src_idx >= src_q.size()) || (stall_en && ($urandom_range(0, 1) == 1));
    #1;
    if (read_data_enable) begin
      rd_cyc_q.push_back(cyc);
      rd_data_q.push_back(read_data);
      if (read_fifo_full) rd_viol++;
    end
    if (write_data_enable) begin
      wr_cyc_q.push_back(cyc);
      if (write_fifo_empty || src_idx >= src_q.size()) wr_viol++;
      else begin
        pend_word = src_q[src_idx];
        src_idx++;
        wr_pend = 1'b1;
      end
    end
    if (cmd_done) begin
      done_cyc_q.push_back(cyc);
      done_err_q.push_back(cmd_error);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (device_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready"}, 32'(device_ready), 1);
  endtask

  task automatic run_cmd(input string tag, input bit rd, input bit wr, input logic [31:0] blk,
                         input logic [7:0] cnt, input logic [1:0] exp_err,
                         output int t, output int d);
    int n, d0;
    wait_ready(tag);
    d0 = done_cyc_q.size();
    t = cyc;
    read_cmd = rd;
    write_cmd = wr;
    block_address = blk;
    block_count = cnt;
    @(negedge clk);
    read_cmd = 1'b0;
    write_cmd = 1'b0;
    block_address = $urandom;
    block_count = 8'($urandom);
    n = 0;
    while (done_cyc_q.size() == d0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    d = -1;
    chk({tag, " done_seen"}, 32'(done_cyc_q.size() > d0), 1);
    if (done_cyc_q.size() > d0) begin
      d = done_cyc_q[d0];
      chk({tag, " error_code"}, 32'(done_err_q[d0]), 32'(exp_err));
      chk({tag, " ready_after_done"}, {device_ready, 31'(cyc - d)}, {1'b1, 31'd1});
    end
    @(negedge clk);
    @(negedge clk);
    chk({tag, " single_done"}, done_cyc_q.size() - d0, 1);
  endtask

  task automatic write_xfer(input string tag, input logic [31:0] blk, input logic [7:0] cnt,
                            input bit stall, input bit ramp);
    int n = int'(cnt) * BS;
    int base = int'(blk) * BS;
    int w0, t, d;
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      w = ramp ? 16'(i) : 16'($urandom);
      src_q.push_back(w);
      ref_mem[base + i] = w;
    end
    w0 = wr_cyc_q.size();
    stall_en = stall;
    run_cmd(tag, 1'b0, 1'b1, blk, cnt, RD_OK, t, d);
    stall_en = 1'b0;
    chk({tag, " strobes"}, wr_cyc_q.size() - w0, n);
    chk({tag, " empty_violations"}, wr_viol, 0);
    if (wr_cyc_q.size() >= w0 + n) begin
      chk({tag, " done_timing"}, d, wr_cyc_q[w0 + n - 1] + 2);
      if (!stall) chk({tag, " first_strobe"}, wr_cyc_q[w0], t + 1);
    end
  endtask

  task automatic read_xfer(input string tag, input logic [31:0] blk, input logic [7:0] cnt,
                           input bit stall);
    logic [15:0] exp_q[$];
    int n = int'(cnt) * BS;
    int base = int'(blk) * BS;
    int r0, t, d;
    for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[base + i]);
    r0 = rd_cyc_q.size();
    stall_en = stall;
    run_cmd(tag, 1'b1, 1'b0, blk, cnt, RD_OK, t, d);
    stall_en = 1'b0;
    chk({tag, " strobes"}, rd_cyc_q.size() - r0, n);
    chk({tag, " full_violations"}, rd_viol, 0);
    for (int i = 0; i < n && r0 + i < rd_data_q.size(); i++)
      chk($sformatf("%s word%0d", tag, i), 32'(rd_data_q[r0 + i]), 32'(exp_q[i]));
    if (rd_cyc_q.size() >= r0 + n) begin
      chk({tag, " done_timing"}, d, rd_cyc_q[r0 + n - 1] + 1);
      if (!stall) begin
        chk({tag, " first_strobe"}, rd_cyc_q[r0], t + 2);
        chk({tag, " gapless"}, rd_cyc_q[r0 + n - 1] - rd_cyc_q[r0], n - 1);
      end
    end
  endtask

  task automatic reject(input string tag, input bit rd, input bit wr, input logic [31:0] blk,
                        input logic [7:0] cnt, input logic [1:0] exp_err);
    int r0 = rd_cyc_q.size();
    int w0 = wr_cyc_q.size();
    int s0 = src_idx;
    int t, d;
    run_cmd(tag, rd, wr, blk, cnt, exp_err, t, d);
    chk({tag, " done_at_t1"}, d, t + 1);
    chk({tag, " no_fifo_traffic"}, (rd_cyc_q.size() - r0) + (wr_cyc_q.size() - w0) + (src_idx - s0), 0);
  endtask

  initial begin
    int n, w0, d0;
    logic [15:0] w;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {device_ready, read_data_enable, write_data_enable, cmd_done, cmd_error, read_data},
        32'd0);
    reset = 1'b0;
    chk("ready_low_at_release", 32'(device_ready), 0);
    @(negedge clk);
    chk("ready_after_release", 32'(device_ready), 1);

    write_xfer("wr_blk3_ramp", 32'd3, 8'd1, 1'b0, 1'b1);
    read_xfer("rd_blk3", 32'd3, 8'd1, 1'b0);
    write_xfer("wr_blk118", 32'd118, 8'd2, 1'b0, 1'b0);
    read_xfer("rd_blk118_boundary", 32'd118, 8'd2, 1'b0);

    reject("range_119x2", 1'b1, 1'b0, 32'd119, 8'd2, RD_ERR_RANGE);
    reject("range_120x1_wr", 1'b0, 1'b1, 32'd120, 8'd1, RD_ERR_RANGE);
    reject("range_count0", 1'b1, 1'b0, 32'd0, 8'd0, RD_ERR_RANGE);
    reject("range_addr_max", 1'b1, 1'b0, 32'hFFFF_FFFF, 8'd1, RD_ERR_RANGE);
    reject("both_cmds", 1'b1, 1'b1, 32'd3, 8'd1, RD_ERR_CMD);

    write_xfer("wr_stall_blk10", 32'd10, 8'd3, 1'b1, 1'b0);
    read_xfer("rd_stall_blk10", 32'd10, 8'd3, 1'b1);
    read_xfer("rd_stall_blk118", 32'd118, 8'd2, 1'b1);

    // write interrupted by reset after 100 words have reached the RAM
    write_xfer("wr_blk20_base", 32'd20, 8'd1, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      w = 16'($urandom);
      src_q.push_back(w);
      ref_mem[20 * BS + i] = w;
    end
    wait_ready("rst_wr");
    w0 = wr_cyc_q.size();
    d0 = done_cyc_q.size();
    write_cmd = 1'b1;
    block_address = 32'd20;
    block_count = 8'd1;
    @(negedge clk);
    write_cmd = 1'b0;
    n = 0;
    while (wr_cyc_q.size() - w0 < 100 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("rst_wr busy_before_reset", 32'(device_ready), 0);
    #5 reset = 1'b1;
    #1;
    chk("rst_wr async_outputs", {device_ready, read_data_enable, write_data_enable, cmd_done, cmd_error, read_data},
        32'd0);
    chk("rst_wr strobes", wr_cyc_q.size() - w0, 100);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_wr ready_after_release", 32'(device_ready), 1);
    chk("rst_wr no_done", done_cyc_q.size() - d0, 0);
    read_xfer("rd_blk20_after_reset", 32'd20, 8'd1, 1'b0);

`ifdef RAMDISK_WRITE_PROTECT_EN
    write_protect = 1'b1;
    for (int i = 0; i < 4; i++) src_q.push_back(16'($urandom));
    reject("wp_write", 1'b0, 1'b1, 32'd3, 8'd1, RD_ERR_WP);
    reject("wp_range_priority", 1'b0, 1'b1, 32'd119, 8'd2, RD_ERR_RANGE);
    read_xfer("wp_read_allowed", 32'd3, 8'd1, 1'b0);
    write_protect = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
